// File: rtl/dct_pkg.sv
// Shared types and constants for the 8-point DCT/IDCT stream engines.
// cos_coe() is evaluated at elaboration only, to fill the lane coefficient ROMs.
package dct_pkg;

    localparam int DCT_N      = 8;
    localparam int DCT_DATA_W = 10;

    typedef struct packed {
        logic signed [DCT_DATA_W-1:0] data;
        logic                         sop;
        logic                         eop;
        logic                         valid;
    } dct_stream_t;

    typedef enum logic {
        FR_IDLE,
        FR_BLOCK
    } frame_state_e;

    // Row k=0 uses cos(pi/4) for every n so the DC term carries the 1/sqrt(2) weight.
    function automatic int cos_coe(input int k, input int n, input int width);
        real ang;
        real v;
        ang = (k == 0) ? 4.0 : real'((2 * n + 1) * k);
        v   = $cos(ang * 3.14159265358979323846 / 16.0) * real'(2 ** (width - 1));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

endpackage

// File: rtl/idct_mac_lane.sv
// One IDCT MAC lane n: X[k]*cos term, even/odd accumulator pair and the drain-bank copy.
module idct_mac_lane
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int COE_WIDTH  = 10,
    parameter int ACC_WIDTH  = 23,
    parameter int LANE       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic        [2:0]            k_i,
    input  logic                         start_i,
    input  logic                         acc_en_i,
    input  logic                         copy_i,
    output logic signed [ACC_WIDTH-1:0]  bank_e_o,
    output logic signed [ACC_WIDTH-1:0]  bank_o_o
);
    localparam int PROD_W = DATA_WIDTH + COE_WIDTH;

    localparam int COE_TAB [DCT_N] = '{
        cos_coe(0, LANE, COE_WIDTH), cos_coe(1, LANE, COE_WIDTH),
        cos_coe(2, LANE, COE_WIDTH), cos_coe(3, LANE, COE_WIDTH),
        cos_coe(4, LANE, COE_WIDTH), cos_coe(5, LANE, COE_WIDTH),
        cos_coe(6, LANE, COE_WIDTH), cos_coe(7, LANE, COE_WIDTH)
    };

    logic signed [COE_WIDTH-1:0] coe;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] e_q, o_q;
    logic signed [ACC_WIDTH-1:0] bank_e_q, bank_o_q;

    assign coe      = COE_WIDTH'(COE_TAB[k_i]);
    assign prod     = PROD_W'(data_i) * PROD_W'(coe);
    assign prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};

    // The bank takes X[7]'s product directly so the drain can start while the accumulators restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q      <= '0;
            o_q      <= '0;
            bank_e_q <= '0;
            bank_o_q <= '0;
        end else begin
            if (start_i) begin
                e_q <= prod_ext;
                o_q <= '0;
            end else if (acc_en_i) begin
                if (k_i[0]) o_q <= o_q + prod_ext;
                else        e_q <= e_q + prod_ext;
            end
            if (copy_i) begin
                bank_e_q <= e_q;
                bank_o_q <= o_q + prod_ext;
            end
        end
    end

    assign bank_e_o = bank_e_q;
    assign bank_o_o = bank_o_q;

endmodule

// File: rtl/idct8_stream.sv
// 8-point sample-serial 1-D IDCT: framing FSM, four MAC lanes, drain butterfly and rounding.
// Build macro IDCT_SAT_EN saturates the rounded output; without it the output wraps.
//
// state    | meaning
// FR_IDLE  | no block open, waiting for in_sop
// FR_BLOCK | block open, kidx_q is the index of the last accepted X[k]
module idct8_stream
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DATA_W,
    parameter int COE_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic                         in_sop,
    input  logic                         in_eop,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic                         frame_err
);
    localparam int ACC_WIDTH = DATA_WIDTH + COE_WIDTH + 3;
    localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH + 1)'(2 ** (COE_WIDTH - 1));

    frame_state_e fr_q;
    logic [2:0]   kidx_q, k_nxt, lane_k;
    logic         start, acc_en, copy, err;
    logic         err_q;

    always_comb begin
        k_nxt  = kidx_q + 3'd1;
        start  = 1'b0;
        acc_en = 1'b0;
        copy   = 1'b0;
        err    = 1'b0;
        if (in_valid) begin
            if (in_sop && in_eop) begin
                err = 1'b1;
            end else if (in_sop) begin
                start = 1'b1;
                err   = (fr_q == FR_BLOCK);
            end else if (fr_q != FR_BLOCK) begin
                err = 1'b1;
            end else if (k_nxt == 3'd7) begin
                copy = in_eop;
                err  = !in_eop;
            end else if (in_eop) begin
                err = 1'b1;
            end else begin
                acc_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_q   <= FR_IDLE;
            kidx_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err;
            if (start) begin
                fr_q   <= FR_BLOCK;
                kidx_q <= '0;
            end else if (acc_en) begin
                kidx_q <= k_nxt;
            end else if (copy || err) begin
                fr_q <= FR_IDLE;
            end
        end
    end

    assign lane_k = start ? 3'd0 : k_nxt;

    logic signed [ACC_WIDTH-1:0] bank_e [DCT_N/2];
    logic signed [ACC_WIDTH-1:0] bank_o [DCT_N/2];

    for (genvar g = 0; g < DCT_N / 2; g++) begin : g_lane
        idct_mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .COE_WIDTH (COE_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .LANE      (g)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_i  (in_data),
            .k_i     (lane_k),
            .start_i (start),
            .acc_en_i(acc_en),
            .copy_i  (copy),
            .bank_e_o(bank_e[g]),
            .bank_o_o(bank_o[g])
        );
    end

    logic                      drn_act_q;
    logic [2:0]                drn_idx_q;
    logic [1:0]                lane_sel;
    logic signed [ACC_WIDTH:0] e_ext, o_ext, bf_d, bf_q;
    logic                      s1_valid_q, s1_sop_q, s1_eop_q;
    logic [DATA_WIDTH-1:0]     data_d;
    dct_stream_t               out_q;

    // x[7-n] reuses lane n with the odd half subtracted.
    always_comb begin
        lane_sel = drn_idx_q[2] ? ~drn_idx_q[1:0] : drn_idx_q[1:0];
        e_ext    = (ACC_WIDTH + 1)'(bank_e[lane_sel]);
        o_ext    = (ACC_WIDTH + 1)'(bank_o[lane_sel]);
        bf_d     = drn_idx_q[2] ? e_ext - o_ext : e_ext + o_ext;
    end

`ifdef IDCT_SAT_EN
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - 1;
    logic signed [ACC_WIDTH:0] rnd;
    assign rnd = (bf_q + RND) >>> COE_WIDTH;
    always_comb begin
        if (rnd > SAT_MAX)      data_d = DATA_WIDTH'(SAT_MAX);
        else if (rnd < SAT_MIN) data_d = DATA_WIDTH'(SAT_MIN);
        else                    data_d = DATA_WIDTH'(rnd);
    end
`else
    assign data_d = DATA_WIDTH'((bf_q + RND) >>> COE_WIDTH);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drn_act_q  <= 1'b0;
            drn_idx_q  <= '0;
            bf_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            out_q      <= '0;
        end else begin
            if (copy) begin
                drn_act_q <= 1'b1;
                drn_idx_q <= '0;
            end else if (drn_act_q) begin
                drn_idx_q <= drn_idx_q + 3'd1;
                if (drn_idx_q == 3'd7) drn_act_q <= 1'b0;
            end
            bf_q       <= bf_d;
            s1_valid_q <= drn_act_q;
            s1_sop_q   <= drn_act_q && (drn_idx_q == 3'd0);
            s1_eop_q   <= drn_act_q && (drn_idx_q == 3'd7);
            out_q.valid <= s1_valid_q;
            out_q.sop   <= s1_sop_q;
            out_q.eop   <= s1_eop_q;
            out_q.data  <= s1_valid_q ? data_d : '0;
        end
    end

    // A bank copy may only coincide with the last drain read.
    assert property (@(posedge clk) disable iff (!rst_n)
        copy |-> (!drn_act_q || drn_idx_q == 3'd7));

    assign out_data  = out_q.data;
    assign out_valid = out_q.valid;
    assign out_sop   = out_q.sop;
    assign out_eop   = out_q.eop;
    assign frame_err = err_q;

endmodule

// File: tb/tb_idct8_stream.sv
// Self-checking bench for idct8_stream: directed and random blocks against a direct-sum IDCT model.
module tb_idct8_stream;
    localparam int  DW = 10;
    localparam real PI = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] in_data;
    logic                 in_valid, in_sop, in_eop;
    logic signed [DW-1:0] out_data;
    logic                 out_valid, out_sop, out_eop, frame_err;

    idct8_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        bit sop;
        bit eop;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_err    = 0;
    bit   mute     = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference: x[n] = sum_k X[k] * round(cos((2n+1)k*pi/16) * 512), k=0 row at cos(pi/4), n=0..7.
    function automatic int rom(input int k, input int n);
        real a;
        a = (k == 0) ? 4.0 : real'((2 * n + 1) * k);
        return $rtoi($floor($cos(a * PI / 16.0) * 512.0 + 0.5));
    endfunction

    function automatic void ref_block(input int x[8], output int y[8]);
        longint s;
        for (int n = 0; n < 8; n++) begin
            s = 0;
            for (int k = 0; k < 8; k++) s += longint'(x[k]) * longint'(rom(k, n));
            s = (s + 512) >>> 10;
`ifdef IDCT_SAT_EN
            if (s > 511) s = 511;
            if (s < -512) s = -512;
`else
            s = s & 1023;
            if (s >= 512) s -= 1024;
`endif
            y[n] = int'(s);
        end
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && !mute) begin
            if (frame_err) n_err++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_sop", out_sop, e.sop);
                    check("out_eop", out_eop, e.eop);
                    check("out_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input int d, input bit v, input bit s, input bit e);
        @(negedge clk);
        in_data  = DW'(d);
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_block(input int x[8], input int y[8], input int gap_max);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && gap_max > 0) idle(int'($urandom_range(0, gap_max)));
            drive(x[i], 1'b1, i == 0, i == 7);
        end
        for (int j = 0; j < 8; j++) begin
            e.data = y[j];
            e.sop  = (j == 0);
            e.eop  = (j == 7);
            e.cyc  = cyc + 3 + j;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int x[8], y[8], x2[8], y2[8];
        int e0;

        in_data = '0; in_valid = 0; in_sop = 0; in_eop = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        idle(2);

        x = '{0, 0, 0, 0, 0, 0, 0, 0};
        y = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, y, 0); idle(1); wait_drain();

        x = '{64, 0, 0, 0, 0, 0, 0, 0};
        y = '{23, 23, 23, 23, 23, 23, 23, 23};
        send_block(x, y, 0); idle(1); wait_drain();

        x = '{0, 100, 0, 0, 0, 0, 0, 0};
        y = '{49, 42, 28, 10, -10, -28, -42, -49};
        send_block(x, y, 0); idle(1); wait_drain();

        x2 = '{-64, 0, 0, 0, 0, 0, 0, 0};
        y2 = '{-23, -23, -23, -23, -23, -23, -23, -23};
        x = '{64, 0, 0, 0, 0, 0, 0, 0};
        y = '{23, 23, 23, 23, 23, 23, 23, 23};
        send_block(x, y, 0); send_block(x2, y2, 0); idle(1); wait_drain();

        // sop, three samples, then a restarting sop with a full block
        e0 = n_err;
        drive(5, 1, 1, 0); drive(-7, 1, 0, 0); drive(9, 1, 0, 0); drive(3, 1, 0, 0);
        for (int k = 0; k < 8; k++) x[k] = int'($urandom_range(0, 1023)) - 512;
        ref_block(x, y);
        send_block(x, y, 0); idle(1); wait_drain();
        check("err_restart", n_err - e0, 1);

        e0 = n_err;
        drive(5, 1, 1, 0);
        for (int k = 1; k < 5; k++) drive(k * 11, 1, 0, 0);
        drive(7, 1, 0, 1);
        idle(12);
        check("err_eop_k5", n_err - e0, 1);

        e0 = n_err;
        drive(3, 1, 1, 1); idle(4);
        check("err_sop_eop", n_err - e0, 1);

        e0 = n_err;
        drive(3, 1, 0, 0); idle(4);
        check("err_no_sop", n_err - e0, 1);

        e0 = n_err;
        drive(40, 1, 1, 0);
        for (int k = 1; k < 8; k++) drive(k, 1, 0, 0);
        idle(12);
        check("err_k7_no_eop", n_err - e0, 1);
        check("err_no_output", exp_q.size(), 0);

        e0 = n_err;
        repeat (12) begin
            for (int k = 0; k < 8; k++) x[k] = int'($urandom_range(0, 1023)) - 512;
            ref_block(x, y);
            send_block(x, y, ($urandom_range(0, 1) == 1) ? 2 : 0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(1); wait_drain();
        check("rand_no_err", n_err - e0, 0);

        x = '{511, 511, 511, 511, 511, 511, 511, 511};
        ref_block(x, y);
`ifdef IDCT_SAT_EN
        y[0] = 511;
`else
        y[0] = 326;
`endif
        send_block(x, y, 0); idle(1); wait_drain();

        x = '{64, 0, 0, 0, 0, 0, 0, 0};
        y = '{23, 23, 23, 23, 23, 23, 23, 23};
        send_block(x, y, 0);
        idle(4);
        check("pre_rst_valid", out_valid, 1);
        mute = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("rst_drain_valid", out_valid, 0);
        check("rst_drain_data", out_data, 0);
        @(negedge clk);
        check("rst_drain_valid_next", out_valid, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mute  = 1'b0;
        idle(2);

        for (int k = 0; k < 8; k++) x[k] = int'($urandom_range(0, 1023)) - 512;
        ref_block(x, y);
        send_block(x, y, 0); idle(1); wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
